bus_arbiter: RTL and testbench

- Shares the single system Bus_if between two bus masters: M0 (instruction fetch) and M1 (data access).
- Sits between the CPU bus ports and the address-prefix bus decoder.
- Uses zero-latency combinational forwarding of the granted master. Ownership is held for the whole transaction while the slave stalls.
- Round-robin arbitration on contention.

---
 rtl/bus_arbiter_pkg.sv | 27 ++
 rtl/bus_arbiter_if.sv | 26 ++
 rtl/bus_arbiter_rr_pick2.sv | 24 ++
 rtl/bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: bus word types, master ids
// and the read data returned when a stalled transfer is aborted by the watchdog.
package bus_arbiter_pkg;

    typedef logic [31:0] Word_t;
    typedef logic [3:0]  ByteMask_t;
    typedef logic [5:0]  Interrupt_t;

    typedef enum logic {
        M0_IFETCH = 1'b0,
        M1_DATA   = 1'b1
    } MasterId_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOCKED,
        ARB_COOLDOWN
    } ArbState_t;

    localparam Word_t BUS_ARB_TIMEOUT_DATA = 32'hFFFF_FFFF;
    localparam int    WD_WIDTH             = 8;

    function automatic MasterId_t otherMaster(input MasterId_t id);
        return (id == M0_IFETCH) ? M1_DATA : M0_IFETCH;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// One system bus port. The requester uses the master modport, the responder
// (slave or arbiter acting as a slave) uses the slave modport.
interface bus_arbiter_if;
    import bus_arbiter_pkg::*;

    Word_t      address;
    logic       read;
    logic       write;
    Word_t      data_wr;
    ByteMask_t  mask;
    logic       stall;
    Word_t      data_rd;
    Word_t      data_rd_2;
    Interrupt_t interrupt;

    modport master (
        output address, read, write, data_wr, mask,
        input  stall, data_rd, data_rd_2, interrupt
    );

    modport slave (
        input  address, read, write, data_wr, mask,
        output stall, data_rd, data_rd_2, interrupt
    );

endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins, a tie
// goes to the master that was not served last, and with no request the grant rests on last.
module bus_arbiter_rr_pick2
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  MasterId_t  last_i,
    output MasterId_t  grant_o,
    output logic       valid_o
);

    always_comb begin
        grant_o = last_i;
        unique case (req_i)
            2'b01:   grant_o = M0_IFETCH;
            2'b10:   grant_o = M1_DATA;
            2'b11:   grant_o = otherMaster(last_i);
            default: grant_o = last_i;
        endcase
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with zero-latency forwarding and stall locking.
// Optional stall watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int    FIRST_WINNER   = 0,
    parameter int    TIMEOUT_CYCLES = 255,
    parameter Word_t TIMEOUT_DATA   = BUS_ARB_TIMEOUT_DATA
)(
    input  logic              clk,
    input  logic              rst_n,
    bus_arbiter_if.slave      m0,
    bus_arbiter_if.slave      m1,
    bus_arbiter_if.master     s,
    output logic              bus_timeout_o,
    output MasterId_t         owner_o
);

    localparam MasterId_t RESET_LAST = (FIRST_WINNER == 0) ? M1_DATA : M0_IFETCH;

    ArbState_t  state_q;
    MasterId_t  lockOwner_q;
    MasterId_t  lastServed_q;

    logic [1:0] req;
    MasterId_t  pickGrant;
    logic       pickValid;
    MasterId_t  owner;
    logic       locked;
    logic       coolDown;
    logic       ownerReq;
    logic       forward;
    logic       timeoutHit;
    logic       complete;
    logic       lockStart;
    logic       abortLock;
    Word_t      retData;
    Word_t      retData2;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    bus_arbiter_rr_pick2 u_pick (
        .req_i   (req),
        .last_i  (lastServed_q),
        .grant_o (pickGrant),
        .valid_o (pickValid)
    );

    assign locked   = (state_q == ARB_LOCKED);
    assign coolDown = (state_q == ARB_COOLDOWN);
    assign owner    = locked ? lockOwner_q : pickGrant;
    assign ownerReq = locked ? req[lockOwner_q] : pickValid;
    assign forward  = ownerReq & ~coolDown;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [WD_WIDTH-1:0] wdCnt_q;

    // The counter covers every stalled cycle of the current transfer, including
    // the one that takes the lock, so the limit is reached on the Nth stalled cycle.
    assign timeoutHit = forward & s.stall & (wdCnt_q == WD_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdCnt_q <= '0;
        end else if (forward && s.stall && !timeoutHit) begin
            wdCnt_q <= wdCnt_q + 1'b1;
        end else begin
            wdCnt_q <= '0;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    assign complete      = forward & (~s.stall | timeoutHit);
    assign lockStart     = forward & s.stall & ~timeoutHit;
    assign abortLock     = locked & ~ownerReq;
    assign bus_timeout_o = timeoutHit;
    assign owner_o       = owner;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            lockOwner_q  <= M0_IFETCH;
            lastServed_q <= RESET_LAST;
        end else begin
            unique case (state_q)
                ARB_IDLE, ARB_LOCKED: begin
                    if (complete) begin
                        state_q      <= timeoutHit ? ARB_COOLDOWN : ARB_IDLE;
                        lastServed_q <= owner;
                    end else if (lockStart) begin
                        state_q     <= ARB_LOCKED;
                        lockOwner_q <= owner;
                    end else if (abortLock) begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_COOLDOWN: state_q <= ARB_IDLE;
                default:      state_q <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        s.address = '0;
        s.read    = 1'b0;
        s.write   = 1'b0;
        s.data_wr = '0;
        s.mask    = '0;
        if (forward) begin
            if (owner == M1_DATA) begin
                s.address = m1.address;
                s.read    = m1.read;
                s.write   = m1.write;
                s.data_wr = m1.data_wr;
                s.mask    = m1.mask;
            end else begin
                s.address = m0.address;
                s.read    = m0.read;
                s.write   = m0.write;
                s.data_wr = m0.data_wr;
                s.mask    = m0.mask;
            end
        end
    end

    assign retData  = timeoutHit ? TIMEOUT_DATA : s.data_rd;
    assign retData2 = timeoutHit ? TIMEOUT_DATA : s.data_rd_2;

    // A requesting master that is not being served is held off; during the
    // cool-down cycle nobody is served.
    always_comb begin
        m0.stall     = req[0];
        m0.data_rd   = '0;
        m0.data_rd_2 = '0;
        m1.stall     = req[1];
        m1.data_rd   = '0;
        m1.data_rd_2 = '0;
        if (!coolDown) begin
            if (owner == M0_IFETCH) begin
                m0.stall     = ownerReq & s.stall & ~timeoutHit;
                m0.data_rd   = retData;
                m0.data_rd_2 = retData2;
            end else begin
                m1.stall     = ownerReq & s.stall & ~timeoutHit;
                m1.data_rd   = retData;
                m1.data_rd_2 = retData2;
            end
        end
    end

    assign m0.interrupt = s.interrupt;
    assign m1.interrupt = s.interrupt;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; the watchdog scenario is
// selected by BUS_ARB_TIMEOUT_EN, otherwise an indefinite stall is checked.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic busTimeout;
    logic owner;
    int   checks = 0;
    int   errors = 0;

    bus_arbiter_if m0If ();
    bus_arbiter_if m1If ();
    bus_arbiter_if sIf ();

    always #5 clk = ~clk;

    bus_arbiter #(
        .FIRST_WINNER   (0),
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_DATA   (32'hFFFF_FFFF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0            (m0If),
        .m1            (m1If),
        .s             (sIf),
        .bus_timeout_o (busTimeout),
        .owner_o       (owner)
    );

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        m0If.address = '0; m0If.read = 1'b0; m0If.write = 1'b0; m0If.data_wr = '0; m0If.mask = '0;
        m1If.address = '0; m1If.read = 1'b0; m1If.write = 1'b0; m1If.data_wr = '0; m1If.mask = '0;
        sIf.stall = 1'b0; sIf.data_rd = '0; sIf.data_rd_2 = '0; sIf.interrupt = '0;
    endtask

    task automatic doReset();
        clearInputs();
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clearInputs();
        rst_n = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (sIf.read !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_read got %b exp 0", sIf.read); end
        checks++; if (sIf.write !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_write got %b exp 0", sIf.write); end
        checks++; if (m0If.stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_m0_stall got %b exp 0", m0If.stall); end
        checks++; if (m1If.stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_m1_stall got %b exp 0", m1If.stall); end
        checks++; if (busTimeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_timeout got %b exp 0", busTimeout); end
        checks++; if (owner !== 1'b1) begin errors++; $display("[TB] FAIL reset_owner got %b exp 1", owner); end
        nextCycle();
    endtask

    task automatic test_single_read();
        m0If.address = 32'h0000_0010;
        m0If.read    = 1'b1;
        m0If.mask    = 4'hF;
        sIf.stall    = 1'b0;
        sIf.data_rd  = 32'h1234_5678;
        @(negedge clk);
        checks++; if (sIf.address !== 32'h0000_0010) begin errors++; $display("[TB] FAIL single_s_address got %h exp 00000010", sIf.address); end
        checks++; if (sIf.read !== 1'b1) begin errors++; $display("[TB] FAIL single_s_read got %b exp 1", sIf.read); end
        checks++; if (sIf.mask !== 4'hF) begin errors++; $display("[TB] FAIL single_s_mask got %h exp f", sIf.mask); end
        checks++; if (m0If.data_rd !== 32'h1234_5678) begin errors++; $display("[TB] FAIL single_m0_data_rd got %h exp 12345678", m0If.data_rd); end
        checks++; if (m0If.stall !== 1'b0) begin errors++; $display("[TB] FAIL single_m0_stall got %b exp 0", m0If.stall); end
        checks++; if (owner !== 1'b0) begin errors++; $display("[TB] FAIL single_owner got %b exp 0", owner); end
        checks++; if (m1If.data_rd !== 32'h0) begin errors++; $display("[TB] FAIL single_m1_data_rd got %h exp 0", m1If.data_rd); end
        nextCycle();
        clearInputs();
    endtask

    task automatic test_round_robin();
        logic  expOwner;
        logic  otherStall;
        Word_t expAddr;
        doReset();
        m0If.address = 32'h0000_0100; m0If.read = 1'b1;
        m1If.address = 32'h0000_0200; m1If.read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expOwner   = (i % 2 == 1);
            expAddr    = expOwner ? 32'h0000_0200 : 32'h0000_0100;
            otherStall = expOwner ? m0If.stall : m1If.stall;
            checks++; if (owner !== expOwner) begin errors++; $display("[TB] FAIL rr_owner cycle %0d got %b exp %b", i, owner, expOwner); end
            checks++; if (sIf.address !== expAddr) begin errors++; $display("[TB] FAIL rr_s_address cycle %0d got %h exp %h", i, sIf.address, expAddr); end
            checks++; if (otherStall !== 1'b1) begin errors++; $display("[TB] FAIL rr_loser_stall cycle %0d got %b exp 1", i, otherStall); end
            nextCycle();
        end
        clearInputs();
    endtask

    task automatic test_lock_stall();
        m0If.address = 32'h0000_0040; m0If.read = 1'b1;
        nextCycle();
        m1If.address = 32'h0000_0080; m1If.write = 1'b1; m1If.data_wr = 32'hCAFE_F00D; m1If.mask = 4'h3;
        sIf.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sIf.stall = 1'b0;
            @(negedge clk);
            checks++; if (owner !== 1'b1) begin errors++; $display("[TB] FAIL lock_owner cycle %0d got %b exp 1", i, owner); end
            checks++; if (m0If.stall !== 1'b1) begin errors++; $display("[TB] FAIL lock_m0_stall cycle %0d got %b exp 1", i, m0If.stall); end
            checks++; if (m1If.stall !== (i != 3)) begin errors++; $display("[TB] FAIL lock_m1_stall cycle %0d got %b exp %b", i, m1If.stall, (i != 3)); end
            checks++; if (sIf.data_wr !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL lock_s_data_wr cycle %0d got %h exp cafef00d", i, sIf.data_wr); end
            nextCycle();
        end
        m1If.write = 1'b0;
        @(negedge clk);
        checks++; if (owner !== 1'b0) begin errors++; $display("[TB] FAIL lock_after_owner got %b exp 0", owner); end
        checks++; if (m0If.stall !== 1'b0) begin errors++; $display("[TB] FAIL lock_after_m0_stall got %b exp 0", m0If.stall); end
        checks++; if (sIf.address !== 32'h0000_0040) begin errors++; $display("[TB] FAIL lock_after_s_address got %h exp 00000040", sIf.address); end
        nextCycle();
        clearInputs();
    endtask

    task automatic test_abort_and_reset();
        m0If.address = 32'h0000_0044; m0If.read = 1'b1;
        m1If.address = 32'h0000_0088; m1If.write = 1'b1;
        sIf.stall = 1'b1;
        @(negedge clk);
        checks++; if (owner !== 1'b1) begin errors++; $display("[TB] FAIL abort_grant got %b exp 1", owner); end
        nextCycle();
        m1If.write = 1'b0;
        @(negedge clk);
        checks++; if (owner !== 1'b1) begin errors++; $display("[TB] FAIL abort_held_owner got %b exp 1", owner); end
        checks++; if (m0If.stall !== 1'b1) begin errors++; $display("[TB] FAIL abort_m0_stall got %b exp 1", m0If.stall); end
        checks++; if (sIf.read !== 1'b0) begin errors++; $display("[TB] FAIL abort_s_read got %b exp 0", sIf.read); end
        nextCycle();
        sIf.stall = 1'b0;
        @(negedge clk);
        checks++; if (owner !== 1'b0) begin errors++; $display("[TB] FAIL abort_next_owner got %b exp 0", owner); end
        checks++; if (sIf.read !== 1'b1) begin errors++; $display("[TB] FAIL abort_next_s_read got %b exp 1", sIf.read); end
        nextCycle();
        clearInputs();
        m1If.write = 1'b1;
        sIf.stall  = 1'b1;
        nextCycle();
        rst_n = 1'b0;
        clearInputs();
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (owner !== 1'b1) begin errors++; $display("[TB] FAIL midreset_owner got %b exp 1", owner); end
        checks++; if (m0If.stall !== 1'b0) begin errors++; $display("[TB] FAIL midreset_m0_stall got %b exp 0", m0If.stall); end
        checks++; if (m1If.stall !== 1'b0) begin errors++; $display("[TB] FAIL midreset_m1_stall got %b exp 0", m1If.stall); end
        checks++; if (sIf.write !== 1'b0) begin errors++; $display("[TB] FAIL midreset_s_write got %b exp 0", sIf.write); end
        nextCycle();
        m0If.read = 1'b1; m0If.address = 32'h0000_00C0;
        @(negedge clk);
        checks++; if (owner !== 1'b0) begin errors++; $display("[TB] FAIL midreset_unlocked_owner got %b exp 0", owner); end
        checks++; if (m0If.stall !== 1'b0) begin errors++; $display("[TB] FAIL midreset_unlocked_m0_stall got %b exp 0", m0If.stall); end
        nextCycle();
        clearInputs();
    endtask

    task automatic test_interrupt();
        m1If.write = 1'b1;
        sIf.stall = 1'b1;
        sIf.interrupt = 6'b000101;
        @(negedge clk);
        checks++; if (m0If.interrupt !== 6'b000101) begin errors++; $display("[TB] FAIL irq_m0 got %b exp 000101", m0If.interrupt); end
        checks++; if (m1If.interrupt !== 6'b000101) begin errors++; $display("[TB] FAIL irq_m1 got %b exp 000101", m1If.interrupt); end
        nextCycle();
        clearInputs();
        sIf.interrupt = 6'b101010;
        @(negedge clk);
        checks++; if (m0If.interrupt !== 6'b101010) begin errors++; $display("[TB] FAIL irq_idle_m0 got %b exp 101010", m0If.interrupt); end
        checks++; if (m1If.interrupt !== 6'b101010) begin errors++; $display("[TB] FAIL irq_idle_m1 got %b exp 101010", m1If.interrupt); end
        nextCycle();
        clearInputs();
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        m0If.address = 32'h0000_0300; m0If.read = 1'b1;
        sIf.stall = 1'b1;
        sIf.data_rd = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (m0If.stall !== 1'b1) begin errors++; $display("[TB] FAIL wd_stall cycle %0d got %b exp 1", i, m0If.stall); end
            checks++; if (busTimeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_early_pulse cycle %0d got %b exp 0", i, busTimeout); end
            nextCycle();
        end
        @(negedge clk);
        checks++; if (m0If.stall !== 1'b0) begin errors++; $display("[TB] FAIL wd_abort_stall got %b exp 0", m0If.stall); end
        checks++; if (m0If.data_rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wd_abort_data got %h exp ffffffff", m0If.data_rd); end
        checks++; if (busTimeout !== 1'b1) begin errors++; $display("[TB] FAIL wd_pulse got %b exp 1", busTimeout); end
        nextCycle();
        @(negedge clk);
        checks++; if (sIf.read !== 1'b0) begin errors++; $display("[TB] FAIL wd_cooldown_s_read got %b exp 0", sIf.read); end
        checks++; if (busTimeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_pulse_end got %b exp 0", busTimeout); end
        nextCycle();
        @(negedge clk);
        checks++; if (sIf.read !== 1'b1) begin errors++; $display("[TB] FAIL wd_resume_s_read got %b exp 1", sIf.read); end
        nextCycle();
        clearInputs();
        nextCycle();
    endtask
`else
    task automatic test_no_timeout();
        m0If.address = 32'h0000_0300; m0If.read = 1'b1;
        sIf.stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (m0If.stall !== 1'b1) begin errors++; $display("[TB] FAIL hold_stall cycle %0d got %b exp 1", i, m0If.stall); end
            checks++; if (busTimeout !== 1'b0) begin errors++; $display("[TB] FAIL hold_pulse cycle %0d got %b exp 0", i, busTimeout); end
            checks++; if (sIf.read !== 1'b1) begin errors++; $display("[TB] FAIL hold_s_read cycle %0d got %b exp 1", i, sIf.read); end
            nextCycle();
        end
        clearInputs();
        nextCycle();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        clearInputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_stall();
        test_abort_and_reset();
        test_interrupt();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
